seq_detect_1011: RTL
====================

Name: seq_detect_1011

Overview:
- Serial pattern detector that sits directly downstream of the registered-bit D flip-flop stage.
- Samples that stage's Q output one bit per CLK and detects the pattern 1011, with overlap optional.
- Produces a registered MATCH flag and a saturating match count for lab observation and later stages.
- Moore FSM plus counter; no combinational path from D to any output.

Parameters:
- CNT_W, 8: width of the match counter COUNT.
- OVERLAP, 1: 1 lets a completed match's trailing bits seed the next match; 0 restarts detection after each match.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- EN  input  1  bit-valid; D is consumed only on edges where EN=1.
- D  input  1  serial data bit, driven by the upstream flip-flop's Q.
- CNT_CLR  input  1  synchronous clear of COUNT.
- MATCH  output  1  high while the FSM is in state S1011.
- COUNT  output  CNT_W  number of matches detected; saturates.
- STATE  output  3  current FSM state code, for debug.

Behaviour:
- Reset: rising edge with RST=1 forces STATE=S0, MATCH=0, COUNT=0.
  - RST has priority over EN and CNT_CLR.
  - Reset mid-pattern discards the partial pattern.
- State encoding: S0=0, S1=1, S10=2, S101=3, S1011=4. Codes 5-7 are illegal and go to S0 on the next edge regardless of EN.
- Transitions occur only on edges with EN=1. With EN=0, STATE and MATCH hold. The counter still honours CNT_CLR.
- Transition table (next state for D=0 / D=1):
  - S0: S0 / S1
  - S1: S10 / S1
  - S10: S0 / S101
  - S101: S10 / S1011
  - S1011: S10 / S1 when OVERLAP=1
  - S1011: S0 / S1 when OVERLAP=0
- MATCH = (STATE==S1011). It is registered.
  - Latency: MATCH rises in the cycle immediately after the edge that samples the final 1 of 1011.
  - MATCH stays high until the next EN=1 edge; with EN=0 it stays high indefinitely.
- COUNT increments by 1 on every edge where the next state is S1011.
  - Saturating: at 2^CNT_W-1 it holds and does not wrap.
- CNT_CLR=1 sets COUNT=0 on that edge.
  - If CNT_CLR coincides with an increment, the clear wins: COUNT=0.
  - The FSM is unaffected by CNT_CLR.
- Back-to-back matches:
  - OVERLAP=1: 1011011 yields two matches, 3 bits apart. MATCH is high for 1 cycle each time, with a 2-cycle gap.
  - OVERLAP=0: the same stream yields one match.
- X on D while EN=0 must not corrupt state.

Test Plan:
- Reset and hold: RST=1 for 5 cycles (20 ns period), D toggling, EN=1 -> STATE=0, MATCH=0, COUNT=0 throughout. On the first edge after RST falls, normal detection starts.
- Single match: EN=1, D=1,0,1,1 on consecutive edges -> MATCH=1 in the cycle after the 4th edge only, COUNT=1, STATE=4. A following D=0 gives STATE=2 and MATCH=0.
- Overlap: D=1,0,1,1,0,1,1 -> OVERLAP=1 gives COUNT=2 with MATCH pulses after edges 4 and 7. Same stream with OVERLAP=0 gives COUNT=1.
- Near misses and EN gating:
  - D=1,0,0,1,1 -> COUNT=0.
  - D=1,0,1 then EN=0 for 4 cycles with D=0, then EN=1 with D=1 -> match, COUNT=1.
- Counter boundaries:
  - CNT_W=2, feed 5 matches -> COUNT=3 (saturated).
  - Assert CNT_CLR on the same edge as a 6th match -> COUNT=0 and MATCH=1.
- Reset mid-operation: D=1,0,1, then RST=1 for 1 cycle, then D=1 -> no match, STATE=1, COUNT unchanged at 0.

Source files
------------

// File: rtl/seq_detect_1011.sv
// seq_detect_1011: Moore detector for the serial pattern 1011 with a saturating match counter.
// Revision 1.0 - initial release.
`default_nettype none

module seq_detect_1011 #(
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             CNT_CLR,
  output logic             MATCH,
  output logic [CNT_W-1:0] COUNT,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;
  logic   hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S0:    if (EN) state_nxt = D ? S1 : S0;
      S1:    if (EN) state_nxt = D ? S1 : S10;
      S10:   if (EN) state_nxt = D ? S101 : S0;
      S101:  if (EN) state_nxt = D ? S1011 : S10;
      S1011: if (EN) state_nxt = D ? S1 : (OVERLAP ? S10 : S0);
      // Unreachable codes recover without waiting for a valid bit.
      default: state_nxt = S0;
    endcase
  end

  // S1011 cannot follow itself, so reaching it on a valid bit is a new match.
  assign hit = EN && (state_nxt == S1011);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S0;
      MATCH <= 1'b0;
      COUNT <= '0;
    end else begin
      state <= state_nxt;
      MATCH <= (state_nxt == S1011);
      if (CNT_CLR) begin
        COUNT <= '0;
      end else if (hit && (COUNT != CNT_MAX)) begin
        COUNT <= COUNT + CNT_ONE;
      end
    end
  end

  assign STATE = state;

endmodule

`default_nettype wire
